inst_buffer: RTL and testbench

//  N-wide circular instruction queue between fetch and dispatch. Accepts up to N fetched

---
 rtl/inst_buffer.sv | 152 +++++++++++++++
 tb/tb_inst_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// N-wide circular instruction queue between fetch and dispatch.
// Fetch writes up to N packets per cycle; dispatch sees the oldest N entries and retires a prefix.
package inst_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_packet_t;
endpackage

module inst_buffer_chk #(
    parameter int N     = 3,
    parameter int DEPTH = 16
) (
    input logic                       clock,
    input logic                       reset,
    input logic                       flush,
    input logic [$clog2(N+1)-1:0]     num_dispatch,
    input logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    // Dispatch must never claim more entries than are occupied; the buffer clamps it.
    always @(posedge clock) begin
        if (!reset && !flush) begin
            assert (CW'(num_dispatch) <= count)
                else $warning("inst_buffer: num_dispatch %0d exceeds count %0d, clamped",
                              num_dispatch, count);
        end
    end
endmodule

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int N     = 3,
    parameter int DEPTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  inst_packet_t [N-1:0]            in_insts,
    input  logic [$clog2(N+1)-1:0]          num_in,
    input  logic [$clog2(N+1)-1:0]          num_dispatch,
    input  logic                            flush,
    output logic [$clog2(N+1)-1:0]          num_accept,
    output inst_packet_t [N-1:0]            out_insts,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(N+1);

    inst_packet_t   entries_q [DEPTH];
    inst_packet_t   entries_d [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  head_d;
    logic [PW-1:0]  tail_q;
    logic [PW-1:0]  tail_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    logic [CW-1:0]  space_s;
    logic [CW-1:0]  num_in_ext_s;
    logic [CW-1:0]  accept_s;
    logic [CW-1:0]  disp_ext_s;
    logic [CW-1:0]  pop_lim_s;
    logic [CW-1:0]  pop_s;

    // Accept and pop amounts; space freed by this cycle's pops is not reused until next cycle.
    always_comb begin
        space_s      = CW'(DEPTH) - count_q;
        num_in_ext_s = CW'(num_in);
        disp_ext_s   = CW'(num_dispatch);
        if (reset || flush) begin
            accept_s = '0;
        end else if (num_in_ext_s < space_s) begin
            accept_s = num_in_ext_s;
        end else begin
            accept_s = space_s;
        end
        if (count_q < CW'(N)) begin
            pop_lim_s = count_q;
        end else begin
            pop_lim_s = CW'(N);
        end
        if (flush) begin
            pop_s = '0;
        end else if (disp_ext_s < pop_lim_s) begin
            pop_s = disp_ext_s;
        end else begin
            pop_s = pop_lim_s;
        end
    end

    assign num_accept = NW'(accept_s);
    assign count      = count_q;

    // Next-state: enqueue at tail, retire from head, flush overrides both.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < accept_s) begin
                entries_d[PW'(tail_q + PW'(i))]       = in_insts[i];
                entries_d[PW'(tail_q + PW'(i))].valid = 1'b1;
            end else begin
                entries_d[PW'(tail_q + PW'(i))] = entries_q[PW'(tail_q + PW'(i))];
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_s);
            tail_d  = tail_q + PW'(accept_s);
            count_d = count_q + accept_s - pop_s;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Dispatch window: lane validity comes from occupancy, not the stored valid bit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_insts[i]       = entries_q[PW'(head_q + PW'(i))];
            out_insts[i].valid = (CW'(i) < count_q) && !flush;
        end
    end

    inst_buffer_chk #(.N(N), .DEPTH(DEPTH)) u_chk (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .num_dispatch (num_dispatch),
        .count        (count_q)
    );
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with N=3, DEPTH=8.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic                 clock;
    logic                 reset;
    inst_packet_t [2:0]   in_insts;
    logic [1:0]           num_in;
    logic [1:0]           num_dispatch;
    logic                 flush;
    logic [1:0]           num_accept;
    inst_packet_t [2:0]   out_insts;
    logic [3:0]           count;

    int checks = 0;
    int errors = 0;

    inst_buffer #(.N(3), .DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_insts     (in_insts),
        .num_in       (num_in),
        .num_dispatch (num_dispatch),
        .flush        (flush),
        .num_accept   (num_accept),
        .out_insts    (out_insts),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n_in, input logic [31:0] base, input int n_disp, input logic fl);
        for (int i = 0; i < 3; i++) begin
            in_insts[i].valid = (i < n_in);
            in_insts[i].pc    = base + 32'(i);
            in_insts[i].inst  = (base + 32'(i)) ^ 32'hDEAD_0000;
        end
        num_in       = 2'(n_in);
        num_dispatch = 2'(n_disp);
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_lane(input string tag, input int lane, input logic [31:0] exp_pc);
        check_val($sformatf("%s_v%0d", tag, lane), 64'(out_insts[lane].valid), 64'd1);
        check_val($sformatf("%s_pc%0d", tag, lane), 64'(out_insts[lane].pc), 64'(exp_pc));
        check_val($sformatf("%s_in%0d", tag, lane), 64'(out_insts[lane].inst),
                  64'(exp_pc ^ 32'hDEAD_0000));
    endtask

    task automatic check_idle(input string tag, input int lane);
        check_val($sformatf("%s_v%0d", tag, lane), 64'(out_insts[lane].valid), 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] next_pc;
        int          acc;
        int          pop;

        reset = 1'b1;
        drive(3, 32'h900, 0, 1'b0);
        #2;
        check_val("rst_accept", 64'(num_accept), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) check_idle("rst", i);
        @(negedge clock);
        reset = 1'b0;

        // Fill A,B,C from empty.
        drive(3, 32'h100, 0, 1'b0); #1;
        check_val("t1_accept", 64'(num_accept), 64'd3);
        tick();
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("t1_count", 64'(count), 64'd3);
        check_lane("t1", 0, 32'h100);
        check_lane("t1", 1, 32'h101);
        check_lane("t1", 2, 32'h102);

        // Push D,E,F while popping 2.
        drive(3, 32'h103, 2, 1'b0); #1;
        check_val("t2_accept", 64'(num_accept), 64'd3);
        tick();
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("t2_count", 64'(count), 64'd4);
        check_lane("t2", 0, 32'h102);
        check_lane("t2", 1, 32'h103);
        check_lane("t2", 2, 32'h104);

        // Fill to full, then pop from full.
        drive(3, 32'h106, 0, 1'b0); #1;
        check_val("t3_acc7", 64'(num_accept), 64'd3);
        tick();
        drive(3, 32'h109, 0, 1'b0); #1;
        check_val("t3_acc_partial", 64'(num_accept), 64'd1);
        tick();
        drive(3, 32'h10A, 0, 1'b0); #1;
        check_val("t3_count_full", 64'(count), 64'd8);
        check_val("t3_acc_full", 64'(num_accept), 64'd0);
        tick();
        drive(3, 32'h10A, 3, 1'b0); #1;
        check_val("t3_acc_fullpop", 64'(num_accept), 64'd0);
        check_lane("t3a", 0, 32'h102);
        tick();
        drive(3, 32'h10A, 0, 1'b0); #1;
        check_val("t3_count_after", 64'(count), 64'd5);
        check_val("t3_acc_next", 64'(num_accept), 64'd3);
        check_lane("t3b", 0, 32'h105);
        check_lane("t3b", 1, 32'h106);
        check_lane("t3b", 2, 32'h107);
        tick();

        // Steady push/pop across wrap, checked against an ordered queue.
        for (int k = 0; k < 8; k++) q.push_back(32'h105 + 32'(k));
        next_pc = 32'h10D;
        for (int c = 0; c < 10; c++) begin
            drive(3, next_pc, 3, 1'b0); #1;
            acc = (8 - q.size() < 3) ? 8 - q.size() : 3;
            pop = (q.size() < 3) ? q.size() : 3;
            check_val($sformatf("t4_acc_c%0d", c), 64'(num_accept), 64'(acc));
            check_val($sformatf("t4_cnt_c%0d", c), 64'(count), 64'(q.size()));
            for (int i = 0; i < 3; i++) begin
                if (i < q.size()) check_lane($sformatf("t4_c%0d", c), i, q[i]);
                else check_idle($sformatf("t4_c%0d", c), i);
            end
            tick();
            for (int i = 0; i < pop; i++) void'(q.pop_front());
            for (int i = 0; i < acc; i++) q.push_back(next_pc + 32'(i));
            next_pc = next_pc + 32'(acc);
        end
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("t4_final_cnt", 64'(count), 64'(q.size()));

        // Flush at count 6 with push and pop requested.
        drive(1, 32'h500, 0, 1'b0);
        tick();
        drive(3, 32'h600, 2, 1'b1); #1;
        check_val("t5_count6", 64'(count), 64'd6);
        check_val("t5_accept", 64'(num_accept), 64'd0);
        for (int i = 0; i < 3; i++) check_idle("t5_flush", i);
        tick();
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("t5_count", 64'(count), 64'd0);
        check_idle("t5_after", 0);

        // Over-dispatch clamps to occupancy.
        drive(1, 32'h700, 0, 1'b0);
        tick();
        drive(0, 32'h0, 3, 1'b0); #1;
        check_val("t6_count1", 64'(count), 64'd1);
        check_lane("t6", 0, 32'h700);
        check_idle("t6", 1);
        tick();
        drive(3, 32'h710, 0, 1'b0); #1;
        check_val("t6_count0", 64'(count), 64'd0);
        tick();
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("t6_count3", 64'(count), 64'd3);
        check_lane("t6b", 0, 32'h710);
        check_lane("t6b", 1, 32'h711);
        check_lane("t6b", 2, 32'h712);

        // Asynchronous reset pulse between edges.
        drive(3, 32'h800, 0, 1'b0); #1;
        reset = 1'b1; #1;
        check_val("ar_count", 64'(count), 64'd0);
        check_val("ar_accept", 64'(num_accept), 64'd0);
        for (int i = 0; i < 3; i++) check_idle("ar", i);
        @(negedge clock);
        reset = 1'b0;
        drive(2, 32'h900, 0, 1'b0); #1;
        check_val("ar_acc_after", 64'(num_accept), 64'd2);
        tick();
        drive(0, 32'h0, 0, 1'b0); #1;
        check_val("ar_count2", 64'(count), 64'd2);
        check_lane("ar", 0, 32'h900);
        check_lane("ar", 1, 32'h901);
        check_idle("ar_tail", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
